// File: rtl/yin_tau_search_pkg.sv
// Shared types and constants for the YIN tau search back end.
// Widths follow the diff word (2*WIDTH) and the tau range (TAUMAX entries).
package yin_pkg;
  localparam int WIDTH            = 16;
  localparam int TAUMAX           = 2048;
  localparam int THRESH           = 26;
  localparam int READ_LATENCY     = 2;
  localparam int THRESH_FRAC_BITS = 8;

  localparam int TAU_W  = $clog2(TAUMAX);
  localparam int DIFF_W = 2 * WIDTH;
  localparam int SUM_W  = DIFF_W + TAU_W;
  localparam int CMP_W  = SUM_W + THRESH_FRAC_BITS + 1;

  typedef logic [DIFF_W-1:0] diff_t;
  typedef logic [TAU_W-1:0]  tau_t;
  typedef logic [SUM_W-1:0]  sum_t;
  typedef logic [CMP_W-1:0]  cmp_t;

  localparam tau_t TAU_LAST = tau_t'(TAUMAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;
endpackage

// File: rtl/yin_tau_search_if.sv
// Diff BRAM read port: the search engine is master while busy.
interface yin_tau_search_if;
  import yin_pkg::*;
  tau_t  diff_addr_out;
  logic  diff_rd_out;
  diff_t diff_data_in;

  modport master (output diff_addr_out, output diff_rd_out, input diff_data_in);
  modport slave  (input diff_addr_out, input diff_rd_out, output diff_data_in);
endinterface

// File: rtl/yin_tau_search_thresh_cmp.sv
// Registered threshold test d*tau*256 < THRESH*(sum+d), plus d >= reference compare.
// Full-width unsigned arithmetic, so the implicit d'(tau) needs no divider.
module yin_thresh_cmp
  import yin_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  vld_in,
  input  diff_t d_in,
  input  tau_t  tau_in,
  input  sum_t  sum_in,
  input  diff_t d_ref_in,
  output logic  vld_out,
  output logic  below_out,
  output logic  ge_out,
  output tau_t  tau_out
);
  cmp_t sum_new, lhs, rhs;
  logic vld_p1_d, vld_p1_q, below_p1_d, below_p1_q, ge_p1_d, ge_p1_q;
  tau_t tau_p1_d, tau_p1_q;

  always_comb begin
    sum_new    = cmp_t'(sum_in) + cmp_t'(d_in);
    lhs        = (cmp_t'(d_in) * cmp_t'(tau_in)) << THRESH_FRAC_BITS;
    rhs        = cmp_t'(THRESH) * sum_new;
    vld_p1_d   = vld_in;
    // Silence gives sum 0; never report that as a hit.
    below_p1_d = (sum_new != '0) && (lhs < rhs);
    ge_p1_d    = (d_in >= d_ref_in);
    tau_p1_d   = tau_in;
  end

  // p1: registered compare results
  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p1_d;
    below_p1_q <= below_p1_d;
    ge_p1_q    <= ge_p1_d;
    tau_p1_q   <= tau_p1_d;
  end

  assign vld_out   = vld_p1_q;
  assign below_out = below_p1_q;
  assign ge_out    = ge_p1_q;
  assign tau_out   = tau_p1_q;
endmodule

// File: rtl/yin_tau_search.sv
// YIN back end: scans d(tau) from the diff BRAM and reports the first local
// minimum below the absolute threshold of the cumulative-mean-normalised d'.
module yin_tau_search
  import yin_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  yin_tau_search_if.master        diff_if,
  output logic                    busy_out,
  output logic                    tau_valid_out,
  output logic                    found_out,
  output tau_t                    tau_out
);
  localparam int RL = READ_LATENCY;

  state_e           state_q, state_d;
  tau_t             addr_q, addr_d;
  logic [RL-1:0]    pipe_vld_q, pipe_vld_d;
  tau_t [RL-1:0]    pipe_tag_q, pipe_tag_d;
  sum_t             sum_q, sum_d;
  diff_t            last_d_q, last_d_d;
  logic             open_q, open_d, decided_q, decided_d;
  tau_t             cand_tau_q, cand_tau_d;
  logic             res_found_q, res_found_d, found_q, found_d;
  tau_t             res_tau_q, res_tau_d, tau_q, tau_d;
  logic             issue, decide_now, dec_found;
  tau_t             dec_tau;
  logic             cmp_vld, cmp_below, cmp_ge;
  tau_t             cmp_tau;

  // cand_d always equals the previous return's d while a run is open, so the
  // comparator can test against last_d without waiting on the decision stage.
  yin_thresh_cmp u_cmp (
    .clk       (clk_in),
    .rst       (rst_in),
    .vld_in    (pipe_vld_q[RL-1]),
    .d_in      (diff_if.diff_data_in),
    .tau_in    (pipe_tag_q[RL-1]),
    .sum_in    (sum_q),
    .d_ref_in  (last_d_q),
    .vld_out   (cmp_vld),
    .below_out (cmp_below),
    .ge_out    (cmp_ge),
    .tau_out   (cmp_tau)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    last_d_d    = last_d_q;
    open_d      = open_q;
    decided_d   = decided_q;
    cand_tau_d  = cand_tau_q;
    res_found_d = res_found_q;
    res_tau_d   = res_tau_q;
    found_d     = found_q;
    tau_d       = tau_q;
    issue       = 1'b0;
    decide_now  = 1'b0;
    dec_found   = 1'b0;
    dec_tau     = '0;

    if (pipe_vld_q[RL-1]) begin
      sum_d    = sum_q + sum_t'(diff_if.diff_data_in);
      last_d_d = diff_if.diff_data_in;
    end

    if (cmp_vld && !decided_q) begin
      if (open_q) begin
        if (!cmp_below || cmp_ge) begin
          decide_now = 1'b1; dec_found = 1'b1; dec_tau = cand_tau_q;
        end else begin
          cand_tau_d = cmp_tau;
          if (cmp_tau == TAU_LAST) begin
            decide_now = 1'b1; dec_found = 1'b1; dec_tau = cmp_tau;
          end
        end
      end else if (cmp_below) begin
        open_d     = 1'b1;
        cand_tau_d = cmp_tau;
        if (cmp_tau == TAU_LAST) begin
          decide_now = 1'b1; dec_found = 1'b1; dec_tau = cmp_tau;
        end
      end else if (cmp_tau == TAU_LAST) begin
        decide_now = 1'b1;
      end
    end
    if (decide_now) begin
      decided_d   = 1'b1;
      res_found_d = dec_found;
      res_tau_d   = dec_tau;
    end

    unique case (state_q)
      ST_IDLE: if (start_in) begin
        state_d     = ST_ISSUE;
        addr_d      = tau_t'(1);
        sum_d       = '0;
        open_d      = 1'b0;
        decided_d   = 1'b0;
        res_found_d = 1'b0;
        res_tau_d   = '0;
      end
      ST_ISSUE: if (!decided_q && !decide_now) begin
        issue  = 1'b1;
        addr_d = addr_q + tau_t'(1);
        if (addr_q == TAU_LAST) state_d = ST_DRAIN;
      end else begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: if (!(|pipe_vld_q) && !cmp_vld) begin
        state_d = ST_DONE;
        found_d = res_found_q;
        tau_d   = res_found_q ? res_tau_q : '0;
      end
      default: state_d = ST_IDLE;
    endcase

    pipe_vld_d    = {pipe_vld_q[RL-2:0], issue};
    pipe_tag_d    = pipe_tag_q;
    pipe_tag_d[0] = addr_q;
    for (int i = 1; i < RL; i++) pipe_tag_d[i] = pipe_tag_q[i-1];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      pipe_vld_q  <= '0;
      sum_q       <= '0;
      open_q      <= 1'b0;
      decided_q   <= 1'b0;
      res_found_q <= 1'b0;
      res_tau_q   <= '0;
      found_q     <= 1'b0;
      tau_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pipe_vld_q  <= pipe_vld_d;
      sum_q       <= sum_d;
      open_q      <= open_d;
      decided_q   <= decided_d;
      res_found_q <= res_found_d;
      res_tau_q   <= res_tau_d;
      found_q     <= found_d;
      tau_q       <= tau_d;
    end
    pipe_tag_q <= pipe_tag_d;
    last_d_q   <= last_d_d;
    cand_tau_q <= cand_tau_d;
  end

  assign diff_if.diff_addr_out = addr_q;
  assign diff_if.diff_rd_out   = issue;
  assign busy_out              = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign tau_valid_out         = (state_q == ST_DONE);
  assign found_out             = found_q;
  assign tau_out               = tau_q;
endmodule

// File: tb/tb_yin_tau_search.sv
// Directed bench for yin_tau_search with a two-cycle diff BRAM model.
module tb_yin_tau_search;
  import yin_pkg::*;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, tau_valid, found;
  tau_t tau;

  yin_tau_search_if dif ();

  yin_tau_search dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .diff_if       (dif),
    .busy_out      (busy),
    .tau_valid_out (tau_valid),
    .found_out     (found),
    .tau_out       (tau)
  );

  always #5 clk = ~clk;

  diff_t mem [TAUMAX];
  diff_t r1, r2;
  always @(posedge clk) begin
    if (dif.diff_rd_out) r1 <= mem[dif.diff_addr_out];
    r2 <= r1;
  end
  assign dif.diff_data_in = r2;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   pulse_cnt, max_addr;
  logic mon_clr;

  always @(posedge clk) begin
    if (mon_clr) begin
      pulse_cnt <= 0;
      max_addr  <= 0;
    end else begin
      if (tau_valid) pulse_cnt <= pulse_cnt + 1;
      if (dif.diff_rd_out && int'(dif.diff_addr_out) > max_addr)
        max_addr <= int'(dif.diff_addr_out);
    end
  end

  task automatic fill(input diff_t v);
    for (int i = 0; i < TAUMAX; i++) mem[i] = v;
  endtask

  task automatic mon_reset();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  // Starts a search; restart_at > 0 re-pulses start that many cycles in.
  task automatic run_search(input int restart_at, output int lat, output bit to);
    mon_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    to  = 1'b1;
    for (int i = 0; i < TAUMAX + 10; i++) begin
      if (tau_valid) begin
        to = 1'b0;
        break;
      end
      start = (restart_at > 0 && i == restart_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mon_clr = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vec_cnt++; if (tau_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %0b want 0", tau_valid); end
    vec_cnt++; if (found !== 1'b0) begin err_cnt++; $display("FAIL reset_found: got %0b want 0", found); end
    vec_cnt++; if (tau !== '0) begin err_cnt++; $display("FAIL reset_tau: got %0d want 0", tau); end
    vec_cnt++; if (dif.diff_rd_out !== 1'b0) begin err_cnt++; $display("FAIL reset_rd: got %0b want 0", dif.diff_rd_out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flat();
    int lat; bit to;
    fill(diff_t'(1000));
    run_search(0, lat, to);
    vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL flat_timeout: got %0d cycles want <= %0d", lat, TAUMAX + 5); end
    vec_cnt++; if (lat > TAUMAX + 5) begin err_cnt++; $display("FAIL flat_latency: got %0d want <= %0d", lat, TAUMAX + 5); end
    vec_cnt++; if (found !== 1'b0) begin err_cnt++; $display("FAIL flat_found: got %0b want 0", found); end
    vec_cnt++; if (tau !== '0) begin err_cnt++; $display("FAIL flat_tau: got %0d want 0", tau); end
    vec_cnt++; if (max_addr != TAUMAX - 1) begin err_cnt++; $display("FAIL flat_last_read: got %0d want %0d", max_addr, TAUMAX - 1); end
    settle();
    vec_cnt++; if (pulse_cnt != 1) begin err_cnt++; $display("FAIL flat_pulses: got %0d want 1", pulse_cnt); end
  endtask

  task automatic test_dip();
    int lat; bit to;
    fill(diff_t'(1000));
    mem[99] = 50; mem[100] = 10; mem[101] = 40;
    run_search(0, lat, to);
    vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL dip_timeout: got %0d cycles want pulse", lat); end
    vec_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL dip_found: got %0b want 1", found); end
    vec_cnt++; if (tau !== tau_t'(100)) begin err_cnt++; $display("FAIL dip_tau: got %0d want 100", tau); end
    vec_cnt++; if (max_addr > 104 || max_addr < 101) begin err_cnt++; $display("FAIL dip_last_read: got %0d want 101..104", max_addr); end
    settle();
    vec_cnt++; if (pulse_cnt != 1) begin err_cnt++; $display("FAIL dip_pulses: got %0d want 1", pulse_cnt); end
  endtask

  task automatic test_silence();
    int lat; bit to;
    fill('0);
    run_search(0, lat, to);
    vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL silence_timeout: got %0d cycles want pulse", lat); end
    vec_cnt++; if (found !== 1'b0) begin err_cnt++; $display("FAIL silence_found: got %0b want 0", found); end
    vec_cnt++; if (tau !== '0) begin err_cnt++; $display("FAIL silence_tau: got %0d want 0", tau); end
  endtask

  task automatic test_tail();
    int lat; bit to;
    fill(diff_t'(1000));
    mem[2045] = 20; mem[2046] = 5; mem[2047] = 1;
    run_search(0, lat, to);
    vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL tail_timeout: got %0d cycles want pulse", lat); end
    vec_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL tail_found: got %0b want 1", found); end
    vec_cnt++; if (tau !== tau_t'(2047)) begin err_cnt++; $display("FAIL tail_tau: got %0d want 2047", tau); end
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    fill(diff_t'(1000));
    mem[200] = 5; mem[201] = 5;
    run_search(60, lat, to);
    vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL equal_timeout: got %0d cycles want pulse", lat); end
    vec_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL equal_found: got %0b want 1", found); end
    vec_cnt++; if (tau !== tau_t'(200)) begin err_cnt++; $display("FAIL equal_tau: got %0d want 200", tau); end
    settle();
    vec_cnt++; if (pulse_cnt != 1) begin err_cnt++; $display("FAIL equal_pulses: got %0d want 1", pulse_cnt); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL equal_idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    int lat; bit to;
    fill(diff_t'(1000));
    mon_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL midrst_busy_before: got %0b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL midrst_busy: got %0b want 0", busy); end
    vec_cnt++; if (dif.diff_rd_out !== 1'b0) begin err_cnt++; $display("FAIL midrst_rd: got %0b want 0", dif.diff_rd_out); end
    vec_cnt++; if (found !== 1'b0 || tau !== '0) begin err_cnt++; $display("FAIL midrst_result: got found=%0b tau=%0d want 0/0", found, tau); end
    repeat (20) @(negedge clk);
    vec_cnt++; if (pulse_cnt != 0) begin err_cnt++; $display("FAIL midrst_pulses: got %0d want 0", pulse_cnt); end
    mem[99] = 50; mem[100] = 10; mem[101] = 40;
    run_search(0, lat, to);
    vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL midrst_rerun_timeout: got %0d cycles want pulse", lat); end
    vec_cnt++; if (found !== 1'b1 || tau !== tau_t'(100)) begin err_cnt++; $display("FAIL midrst_rerun: got found=%0b tau=%0d want 1/100", found, tau); end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_dip();
    test_silence();
    test_tail();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
